// File: rtl/jt900h_muldiv_pkg.sv
// Shared op codes and FSM encoding for the
// iterative multiply/divide unit.
package jt900h_muldiv_pkg;

  localparam logic [1:0] MULU_OP = 2'd0;
  localparam logic [1:0] MULS_OP = 2'd1;
  localparam logic [1:0] DIVU_OP = 2'd2;
  localparam logic [1:0] DIVS_OP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_RUN,
    ST_FIX,
    ST_FIN
  } state_e;

endpackage

// File: rtl/jt900h_muldiv_step.sv
// One shift-add (multiply) or restoring
// shift-subtract (divide) step, W+1 bits wide.
module jt900h_muldiv_step #(
  parameter int W = 16
) (
  input  logic         div,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W:0] sh;
  logic [W:0] dif;
  logic [W:0] sum;

  always_comb begin
    sh  = {hi, lo[W-1]};
    dif = sh - {1'b0, b};
    sum = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    if (div) begin
      // dif[W] is the borrow of the trial subtraction
      hi_o = dif[W] ? sh[W-1:0] : dif[W-1:0];
      lo_o = {lo[W-2:0], ~dif[W]};
    end else begin
      hi_o = sum[W:1];
      lo_o = {sum[0], lo[W-1:1]};
    end
  end

endmodule

// File: rtl/jt900h_muldiv.sv
// Iterative signed/unsigned multiply and divide,
// one result bit per clock-enabled cycle.
module jt900h_muldiv
  import jt900h_muldiv_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] rslt,
  output logic           v,
  output logic           dz
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e         st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [2*W-1:0] rslt_q, rslt_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic           qneg_q, qneg_d;
  logic           rneg_q, rneg_d;
  logic           ovf_q, ovf_d;
  logic           early_q, early_d;
  logic           v_q, v_d;
  logic           dz_q, dz_d;

  logic           is_div, is_sgn, accept;
  logic           a_neg, b_neg;
  logic [2*W-1:0] a_mag, p_fix;
  logic [W-1:0]   lo_mag, b_mag;
  logic [W-1:0]   q_mag, r_mag, q_fix, r_fix, lim;
  logic [W-1:0]   step_hi, step_lo;

  assign is_div = op_q inside {DIVU_OP, DIVS_OP};
  assign is_sgn = !(op_q inside {MULU_OP, DIVU_OP});
  assign accept = start &&
                  (st_q == ST_IDLE || st_q == ST_FIN);

  jt900h_muldiv_step #(.W(W)) u_step (
    .div  (is_div),
    .hi   (acc_q[2*W-1:W]),
    .lo   (acc_q[W-1:0]),
    .b    (b_q),
    .hi_o (step_hi),
    .lo_o (step_lo)
  );

  always_comb begin
    a_neg  = is_sgn &
             (is_div ? acc_q[2*W-1] : acc_q[W-1]);
    b_neg  = is_sgn & b_q[W-1];
    a_mag  = a_neg ? -acc_q : acc_q;
    lo_mag = a_neg ? -acc_q[W-1:0] : acc_q[W-1:0];
    b_mag  = b_neg ? -b_q : b_q;
    q_mag  = acc_q[W-1:0];
    r_mag  = acc_q[2*W-1:W];
    q_fix  = qneg_q ? -q_mag : q_mag;
    r_fix  = rneg_q ? -r_mag : r_mag;
    p_fix  = qneg_q ? -acc_q : acc_q;
    // largest legal magnitude: 2^(W-1) if negative
    lim    = {qneg_q, {(W-1){~qneg_q}}};
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rslt_d  = rslt_q;
    b_d     = b_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovf_d   = ovf_q;
    early_d = early_q;
    v_d     = v_q;
    dz_d    = dz_q;
    unique case (st_q)
      ST_IDLE: ;
      ST_CHECK: begin
        st_d    = ST_RUN;
        cnt_d   = '0;
        early_d = 1'b0;
        b_d     = b_mag;
        qneg_d  = a_neg ^ b_neg;
        rneg_d  = a_neg;
        ovf_d   = is_sgn &&
                  (a_mag[2*W-1:W] >= b_mag);
        acc_d   = is_div ? a_mag
                         : {{W{1'b0}}, lo_mag};
        if (is_div && b_q == '0) begin
          st_d    = ST_FIX;
          early_d = 1'b1;
          rslt_d  = acc_q;
          v_d     = 1'b1;
          dz_d    = 1'b1;
        end else if (is_div && !is_sgn &&
                     acc_q[2*W-1:W] >= b_q) begin
          st_d    = ST_FIX;
          early_d = 1'b1;
          rslt_d  = acc_q;
          v_d     = 1'b1;
          dz_d    = 1'b0;
        end
      end
      ST_RUN: begin
        acc_d = {step_hi, step_lo};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) st_d = ST_FIX;
      end
      ST_FIX: begin
        st_d = ST_FIN;
        if (!early_q) begin
          rslt_d = is_div ? {r_fix, q_fix} : p_fix;
          v_d    = is_div && is_sgn &&
                   (ovf_q || q_mag > lim);
          dz_d   = 1'b0;
        end
      end
      ST_FIN: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (accept) begin
      st_d  = ST_CHECK;
      acc_d = a;
      b_d   = b;
      op_d  = op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      rslt_q  <= '0;
      b_q     <= '0;
      op_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
      early_q <= 1'b0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
    end else if (cen) begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rslt_q  <= rslt_d;
      b_q     <= b_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovf_q   <= ovf_d;
      early_q <= early_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = st_q inside {ST_CHECK, ST_RUN, ST_FIX};
  assign done = (st_q == ST_FIN);
  assign rslt = rslt_q;
  assign v    = v_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_jt900h_muldiv.sv
// Randomized and directed bench for jt900h_muldiv
// against an arithmetic reference model.
module tb_jt900h_muldiv;
  import jt900h_muldiv_pkg::*;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, v, dz;
  logic [31:0] rslt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  jt900h_muldiv #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .rslt  (rslt),
    .v     (v),
    .dz    (dz)
  );

  function automatic void model(
    input  logic [1:0]  o,
    input  logic [31:0] ai,
    input  logic [15:0] bi,
    output logic [31:0] r,
    output logic        ov,
    output logic        oz,
    output int          lat
  );
    longint sa, sb, q, rm;
    ov  = 1'b0;
    oz  = 1'b0;
    lat = W + 2;
    r   = '0;
    case (o)
      MULU_OP: begin
        sa = {48'd0, ai[15:0]};
        sb = {48'd0, bi};
        q  = sa * sb;
        r  = q[31:0];
      end
      MULS_OP: begin
        sa = longint'($signed(ai[15:0]));
        sb = longint'($signed(bi));
        q  = sa * sb;
        r  = q[31:0];
      end
      default: begin
        if (bi == 16'd0) begin
          r = ai; ov = 1'b1; oz = 1'b1; lat = 2;
        end else if (o == DIVU_OP) begin
          if (ai[31:16] >= bi) begin
            r = ai; ov = 1'b1; lat = 2;
          end else begin
            sa = {32'd0, ai};
            sb = {48'd0, bi};
            q  = sa / sb;
            rm = sa % sb;
            r  = {rm[15:0], q[15:0]};
          end
        end else begin
          sa = longint'($signed(ai));
          sb = longint'($signed(bi));
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[15:0], q[15:0]};
          ov = (q > 32767) || (q < -32768);
        end
      end
    endcase
  endfunction

  task automatic run_op(
    input  logic [1:0]  o,
    input  logic [31:0] ai,
    input  logic [15:0] bi,
    output logic [31:0] r,
    output logic        vv,
    output logic        dd,
    output int          lat,
    output logic        bk,
    output logic        bd,
    output logic        dn
  );
    op = o; a = ai; b = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bk = busy;
    op = 2'($urandom); a = $urandom; b = 16'($urandom);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    r = rslt; vv = v; dd = dz; bd = busy;
    @(posedge clk); #1;
    dn = done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, v, dz} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, done, v, dz});
    end
    total++;
    if (rslt !== 32'h0) begin
      bad++;
      $display("FAIL reset_rslt got %h want 0", rslt);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] ai;
    logic [15:0] bi;
    logic [31:0] r;
    logic        ov;
    logic        oz;
    int          lat;
  } vec_t;

  task automatic test_directed;
    vec_t tv [12];
    logic [31:0] r;
    logic vv, dd, bk, bd, dn;
    int lat;
    tv[0]  = '{DIVU_OP, 32'h0001_0000, 16'h0010,
               32'h0000_1000, 0, 0, 18};
    tv[1]  = '{DIVS_OP, 32'hFFFF_FFF9, 16'h0002,
               32'hFFFF_FFFD, 0, 0, 18};
    tv[2]  = '{DIVU_OP, 32'h1234_5678, 16'h0000,
               32'h1234_5678, 1, 1, 2};
    tv[3]  = '{DIVU_OP, 32'h0010_0000, 16'h0010,
               32'h0010_0000, 1, 0, 2};
    tv[4]  = '{MULS_OP, 32'h0000_FFFF, 16'h0002,
               32'hFFFF_FFFE, 0, 0, 18};
    tv[5]  = '{MULU_OP, 32'h0000_FFFF, 16'h0002,
               32'h0001_FFFE, 0, 0, 18};
    tv[6]  = '{DIVS_OP, 32'hFFFF_8000, 16'h0001,
               32'h0000_8000, 0, 0, 18};
    tv[7]  = '{DIVS_OP, 32'h0000_8000, 16'h0001,
               32'h0000_8000, 1, 0, 18};
    tv[8]  = '{DIVS_OP, 32'h0000_0007, 16'hFFFE,
               32'h0001_FFFD, 0, 0, 18};
    tv[9]  = '{DIVS_OP, 32'hDEAD_BEEF, 16'h0000,
               32'hDEAD_BEEF, 1, 1, 2};
    tv[10] = '{MULS_OP, 32'h0000_8000, 16'h8000,
               32'h4000_0000, 0, 0, 18};
    tv[11] = '{MULU_OP, 32'hABCD_0003, 16'h0005,
               32'h0000_000F, 0, 0, 18};
    foreach (tv[i]) begin
      run_op(tv[i].o, tv[i].ai, tv[i].bi,
             r, vv, dd, lat, bk, bd, dn);
      total++;
      if (r !== tv[i].r) begin
        bad++;
        $display("FAIL dir%0d_rslt got %h want %h",
                 i, r, tv[i].r);
      end
      total++;
      if ({vv, dd} !== {tv[i].ov, tv[i].oz}) begin
        bad++;
        $display("FAIL dir%0d_vdz got %b want %b",
                 i, {vv, dd}, {tv[i].ov, tv[i].oz});
      end
      total++;
      if (lat !== tv[i].lat) begin
        bad++;
        $display("FAIL dir%0d_lat got %0d want %0d",
                 i, lat, tv[i].lat);
      end
      total++;
      if ({bk, bd, dn} !== 3'b100) begin
        bad++;
        $display("FAIL dir%0d_hs got %b want 100",
                 i, {bk, bd, dn});
      end
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] ai, r, er;
    logic [15:0] bi;
    logic vv, dd, bk, bd, dn, ev, ez;
    int lat, el, tmp;
    for (int i = 0; i < 60; i++) begin
      o  = 2'($urandom_range(0, 3));
      ai = $urandom;
      bi = 16'($urandom);
      if (o == DIVU_OP) begin
        if (bi != 0 && $urandom_range(0, 3) != 0)
          ai[31:16] = 16'($urandom_range(0, int'(bi) - 1));
        if ($urandom_range(0, 9) == 0) bi = '0;
      end else if (o == DIVS_OP) begin
        tmp = int'($urandom);
        ai  = 32'(tmp >>> 9);
        bi  = 16'($urandom_range(128, 32767));
        if ($urandom_range(0, 1) == 1) bi = -bi;
        if ($urandom_range(0, 9) == 0) bi = '0;
      end
      model(o, ai, bi, er, ev, ez, el);
      run_op(o, ai, bi, r, vv, dd, lat, bk, bd, dn);
      total++;
      if (r !== er) begin
        bad++;
        $display("FAIL rnd%0d_rslt op=%0d a=%h b=%h got %h want %h",
                 i, o, ai, bi, r, er);
      end
      total++;
      if ({vv, dd} !== {ev, ez}) begin
        bad++;
        $display("FAIL rnd%0d_vdz op=%0d a=%h b=%h got %b want %b",
                 i, o, ai, bi, {vv, dd}, {ev, ez});
      end
      total++;
      if (lat !== el) begin
        bad++;
        $display("FAIL rnd%0d_lat got %0d want %0d",
                 i, lat, el);
      end
    end
  endtask

  task automatic test_cen;
    int lat;
    op = DIVU_OP; a = 32'h0001_0000; b = 16'h0010;
    start = 1'b1; cen = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cen = 1'b0; a = $urandom;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      cen = ~cen;
      if (done) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat !== 36) begin
      bad++;
      $display("FAIL cen_lat got %0d want 36", lat);
    end
    total++;
    if (rslt !== 32'h0000_1000) begin
      bad++;
      $display("FAIL cen_rslt got %h want 00001000", rslt);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL cen_hold got %b want 1", done);
    end
    cen = 1'b1;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL cen_clear got %b want 0", done);
    end
  endtask

  task automatic test_ignore_start;
    int ndone;
    logic [31:0] r;
    op = DIVU_OP; a = 32'h0001_0000; b = 16'h0010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    op = MULU_OP; a = 32'h0000_FFFF; b = 16'h0002;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    r = '0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        r = rslt;
      end
    end
    total++;
    if (ndone !== 1) begin
      bad++;
      $display("FAIL ign_count got %0d want 1", ndone);
    end
    total++;
    if (r !== 32'h0000_1000) begin
      bad++;
      $display("FAIL ign_rslt got %h want 00001000", r);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    op = DIVU_OP; a = 32'h0001_0000; b = 16'h0010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(posedge clk); #1;
    end
    total++;
    if (rslt !== 32'h0000_1000 || done !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first got %h/%b want 00001000/1",
               rslt, done);
    end
    op = MULU_OP; a = 32'h0000_FFFF; b = 16'h0002;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept got %b want 1", busy);
    end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat !== 18 || rslt !== 32'h0001_FFFE) begin
      bad++;
      $display("FAIL b2b_second got %0d/%h want 18/0001fffe",
               lat, rslt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int ndone;
    logic [31:0] r;
    logic vv, dd, bk, bd, dn;
    int lat;
    op = DIVU_OP; a = 32'h0001_0000; b = 16'h0010;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, v, dz} !== 4'b0 || rslt !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_out got %b/%h want 0000/0",
               {busy, done, v, dz}, rslt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL rstmid_done got %0d want 0", ndone);
    end
    run_op(DIVU_OP, 32'h0001_0000, 16'h0010,
           r, vv, dd, lat, bk, bd, dn);
    total++;
    if (r !== 32'h0000_1000 || lat !== 18) begin
      bad++;
      $display("FAIL rstmid_fresh got %h/%0d want 00001000/18",
               r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_cen();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
